hough_frame_sequencer: RTL and testbench

HOUGH_FRAME_SEQUENCER -- requirements
Module: hough_frame_sequencer

---
 rtl/hough_pkg.sv | 30 +++
 rtl/hough_bank_mux.sv | 30 +++
 rtl/hough_frame_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_hough_frame_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hough_pkg.sv
// ---------------------------------------------------------------------------
// hough_pkg
// Shared types and constants for the Hough frame sequencer.
//   bank_state_t  : life cycle of one ping-pong BRAM bank
//   WIDTH/HEIGHT  : default image geometry; IMAGE_SIZE is pixels per bank
//   FRAME_CNT_W   : width of the completed-frame counters
//   banks_illegal : flags bank-state pairs the sequencer can never reach
// ---------------------------------------------------------------------------
package hough_pkg;

   localparam int WIDTH       = 512;
   localparam int HEIGHT      = 288;
   localparam int IMAGE_SIZE  = WIDTH * HEIGHT;
   localparam int FRAME_CNT_W = 16;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2,
      READING = 2'd3
   } bank_state_t;

   // Only one writer and one reader exist, so two banks can never both be
   // FILLING or both be READING.
   function automatic logic banks_illegal(input bank_state_t b0,
                                          input bank_state_t b1);
      return (b0 == b1) && ((b0 == FILLING) || (b0 == READING));
   endfunction

endpackage

// File: rtl/hough_bank_mux.sv
// ---------------------------------------------------------------------------
// hough_bank_mux
// Combinational address/enable steering into the two-bank BRAM.
//   wr_en_in, wr_ready, wr_bank, wr_addr_in -> bram_wr_en, bram_wr_addr
//   rd_bank, rd_addr_in                     -> bram_rd_addr
// The bank select bit becomes the BRAM address MSB. No registers, so the
// write and read paths add zero latency.
// ---------------------------------------------------------------------------
module hough_bank_mux #(
   parameter int ADDR_W = 18
) (
   input  logic              wr_en_in,
   input  logic              wr_ready,
   input  logic              wr_bank,
   input  logic [ADDR_W-1:0] wr_addr_in,
   input  logic              rd_bank,
   input  logic [ADDR_W-1:0] rd_addr_in,
   output logic              bram_wr_en,
   output logic [ADDR_W:0]   bram_wr_addr,
   output logic [ADDR_W:0]   bram_rd_addr
);

   import hough_pkg::*;

   // Writes offered while no bank is open are dropped here.
   assign bram_wr_en   = wr_en_in & wr_ready;
   assign bram_wr_addr = {wr_bank, wr_addr_in};
   assign bram_rd_addr = {rd_bank, rd_addr_in};

endmodule

// File: rtl/hough_frame_sequencer.sv
// ---------------------------------------------------------------------------
// hough_frame_sequencer
// Ping-pong bank manager between the hysteresis writer and the Hough reader.
//   clock, reset (sync, active-low)
//   wr_en_in/wr_addr_in/wr_frame_done : writer side, wr_ready back-pressure
//   rd_addr_in/rd_done                : reader side, hough_start kicks a read
//   bram_wr_en/bram_wr_addr/bram_rd_addr : steered BRAM ports
//   frames_written/frames_read        : wrapping completed-frame counters
//   overrun_err                       : sticky, writer ignored wr_ready
// Handshake: a pixel or frame_done is accepted only in a cycle where
// wr_ready=1; anything offered with wr_ready=0 is dropped and flagged.
// Each cycle resolves in order: reader release, writer hand-off, reader
// pick-up, so a bank freed by rd_done is usable by the writer the same cycle.
// ---------------------------------------------------------------------------
module hough_frame_sequencer #(
   parameter int WIDTH  = 512,
   parameter int HEIGHT = 288,
   parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en_in,
   input  logic [ADDR_W-1:0] wr_addr_in,
   input  logic              wr_frame_done,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] rd_addr_in,
   input  logic              rd_done,
   output logic              hough_start,
   output logic              bram_wr_en,
   output logic [ADDR_W:0]   bram_wr_addr,
   output logic [ADDR_W:0]   bram_rd_addr,
   output logic [15:0]       frames_written,
   output logic [15:0]       frames_read,
   output logic              overrun_err
);

   import hough_pkg::*;

   bank_state_t            bank_q [2];
   bank_state_t            bank_d [2];
   logic                   wr_bank_q, wr_bank_d;
   logic                   rd_bank_q, rd_bank_d;
   logic                   rd_busy_q, rd_busy_d;
   logic                   oldest_full_q, oldest_full_d;
   logic                   wr_ready_q, wr_ready_d;
   logic                   hough_start_q, hough_start_d;
   logic                   overrun_q, overrun_d;
   logic [FRAME_CNT_W-1:0] frames_wr_q, frames_wr_d;
   logic [FRAME_CNT_W-1:0] frames_rd_q, frames_rd_d;
   logic                   rd_sel;
   logic                   rd_have;

   always_ff @(posedge clock) begin
      if (!reset) begin
         bank_q[0]     <= FILLING;
         bank_q[1]     <= EMPTY;
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         rd_busy_q     <= 1'b0;
         oldest_full_q <= 1'b0;
         wr_ready_q    <= 1'b1;
         hough_start_q <= 1'b0;
         overrun_q     <= 1'b0;
         frames_wr_q   <= '0;
         frames_rd_q   <= '0;
      end else begin
         bank_q[0]     <= bank_d[0];
         bank_q[1]     <= bank_d[1];
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         rd_busy_q     <= rd_busy_d;
         oldest_full_q <= oldest_full_d;
         wr_ready_q    <= wr_ready_d;
         hough_start_q <= hough_start_d;
         overrun_q     <= overrun_d;
         frames_wr_q   <= frames_wr_d;
         frames_rd_q   <= frames_rd_d;
      end
   end

   always_comb begin
      bank_d[0]     = bank_q[0];
      bank_d[1]     = bank_q[1];
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      rd_busy_d     = rd_busy_q;
      oldest_full_d = oldest_full_q;
      wr_ready_d    = wr_ready_q;
      hough_start_d = 1'b0;
      frames_wr_d   = frames_wr_q;
      frames_rd_d   = frames_rd_q;
      rd_sel        = 1'b0;
      rd_have       = 1'b0;
      overrun_d     = overrun_q | (~wr_ready_q & (wr_en_in | wr_frame_done));

      // Reader release first so the freed bank is visible to the writer.
      if (rd_done && rd_busy_q) begin
         bank_d[rd_bank_q] = EMPTY;
         rd_busy_d         = 1'b0;
         frames_rd_d       = frames_rd_q + 1'b1;
      end

      if (wr_ready_q) begin
         if (wr_frame_done) begin
            bank_d[wr_bank_q] = FULL;
            frames_wr_d       = frames_wr_q + 1'b1;
            // An already-FULL partner is older and keeps the pointer.
            if (bank_d[~wr_bank_q] != FULL) begin
               oldest_full_d = wr_bank_q;
            end
            if (bank_d[~wr_bank_q] == EMPTY) begin
               bank_d[~wr_bank_q] = FILLING;
               wr_bank_d          = ~wr_bank_q;
            end else begin
               wr_ready_d = 1'b0;
            end
         end
      end else begin
         // Stalled writer reopens on the registered view of an EMPTY bank.
         if (bank_q[0] == EMPTY) begin
            bank_d[0]  = FILLING;
            wr_bank_d  = 1'b0;
            wr_ready_d = 1'b1;
         end else if (bank_q[1] == EMPTY) begin
            bank_d[1]  = FILLING;
            wr_bank_d  = 1'b1;
            wr_ready_d = 1'b1;
         end
      end

      // Reader pick-up sees this cycle's hand-off, so hough_start lands on
      // the same edge that would have made the bank FULL.
      if (!rd_busy_d) begin
         if (bank_d[0] == FULL && bank_d[1] == FULL) begin
            rd_sel  = oldest_full_d;
            rd_have = 1'b1;
         end else if (bank_d[0] == FULL) begin
            rd_sel  = 1'b0;
            rd_have = 1'b1;
         end else if (bank_d[1] == FULL) begin
            rd_sel  = 1'b1;
            rd_have = 1'b1;
         end
      end
      if (rd_have) begin
         bank_d[rd_sel] = READING;
         rd_bank_d      = rd_sel;
         rd_busy_d      = 1'b1;
         hough_start_d  = 1'b1;
      end

      if (banks_illegal(bank_q[0], bank_q[1])) begin
         bank_d[0]     = FILLING;
         bank_d[1]     = EMPTY;
         wr_bank_d     = 1'b0;
         wr_ready_d    = 1'b1;
         rd_busy_d     = 1'b0;
         hough_start_d = 1'b0;
      end
   end

   assign wr_ready       = wr_ready_q;
   assign hough_start    = hough_start_q;
   assign overrun_err    = overrun_q;
   assign frames_written = frames_wr_q;
   assign frames_read    = frames_rd_q;

   hough_bank_mux #(
      .ADDR_W (ADDR_W)
   ) u_bank_mux (
      .wr_en_in     (wr_en_in),
      .wr_ready     (wr_ready_q),
      .wr_bank      (wr_bank_q),
      .wr_addr_in   (wr_addr_in),
      .rd_bank      (rd_bank_q),
      .rd_addr_in   (rd_addr_in),
      .bram_wr_en   (bram_wr_en),
      .bram_wr_addr (bram_wr_addr),
      .bram_rd_addr (bram_rd_addr)
   );

endmodule

// File: tb/tb_hough_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hough_frame_sequencer
// Bench for the ping-pong frame sequencer: a hand-derived vector table,
// mid-read reset, a randomized run against a free-list/FIFO model, and a
// counter wrap burst.
// ---------------------------------------------------------------------------
module tb_hough_frame_sequencer;

   localparam int AW = 18;

   logic          clock;
   logic          reset;
   logic          wr_en_in;
   logic [AW-1:0] wr_addr_in;
   logic          wr_frame_done;
   logic          wr_ready;
   logic [AW-1:0] rd_addr_in;
   logic          rd_done;
   logic          hough_start;
   logic          bram_wr_en;
   logic [AW:0]   bram_wr_addr;
   logic [AW:0]   bram_rd_addr;
   logic [15:0]   frames_written;
   logic [15:0]   frames_read;
   logic          overrun_err;

   int n_cmp = 0;
   int n_err = 0;

   hough_frame_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .wr_en_in       (wr_en_in),
      .wr_addr_in     (wr_addr_in),
      .wr_frame_done  (wr_frame_done),
      .wr_ready       (wr_ready),
      .rd_addr_in     (rd_addr_in),
      .rd_done        (rd_done),
      .hough_start    (hough_start),
      .bram_wr_en     (bram_wr_en),
      .bram_wr_addr   (bram_wr_addr),
      .bram_rd_addr   (bram_rd_addr),
      .frames_written (frames_written),
      .frames_read    (frames_read),
      .overrun_err    (overrun_err)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic fd,
                        input logic [AW-1:0] ra, input logic rd);
      wr_en_in      = we;
      wr_addr_in    = wa;
      wr_frame_done = fd;
      rd_addr_in    = ra;
      rd_done       = rd;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Banks are tracked as a free list and a FIFO of completed frames; the
   // FIFO order is what decides which frame the reader gets next.
   logic        m_ready, m_wb, m_busy, m_rb, m_hs, m_ov;
   logic [15:0] m_fw, m_fr;
   int          full_q[$];
   int          free_l[$];

   function automatic bit in_free(input int b);
      foreach (free_l[i]) if (free_l[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void take_free(input int b);
      for (int i = 0; i < free_l.size(); i++) begin
         if (free_l[i] == b) begin
            free_l.delete(i);
            return;
         end
      end
   endfunction

   function automatic void model_reset();
      m_ready = 1'b1; m_wb = 1'b0; m_busy = 1'b0; m_rb = 1'b0;
      m_hs = 1'b0; m_ov = 1'b0; m_fw = '0; m_fr = '0;
      full_q.delete();
      free_l.delete();
      free_l.push_back(1);
   endfunction

   function automatic void model_step(input logic we, input logic fd, input logic rd);
      bit free0_before, free1_before;
      int other;
      free0_before = in_free(0);
      free1_before = in_free(1);
      if (rd && m_busy) begin
         free_l.push_back(int'(m_rb));
         m_busy = 1'b0;
         m_fr++;
      end
      if (m_ready) begin
         if (fd) begin
            full_q.push_back(int'(m_wb));
            m_fw++;
            other = 1 - int'(m_wb);
            if (in_free(other)) begin
               take_free(other);
               m_wb = ~m_wb;
            end else begin
               m_ready = 1'b0;
            end
         end
      end else begin
         if (we || fd) m_ov = 1'b1;
         if (free0_before) begin
            take_free(0); m_wb = 1'b0; m_ready = 1'b1;
         end else if (free1_before) begin
            take_free(1); m_wb = 1'b1; m_ready = 1'b1;
         end
      end
      m_hs = 1'b0;
      if (!m_busy && full_q.size() > 0) begin
         m_rb   = full_q.pop_front() != 0;
         m_busy = 1'b1;
         m_hs   = 1'b1;
      end
   endfunction

   task automatic check_model();
      chk("m_wr_ready", 32'(wr_ready), 32'(m_ready));
      chk("m_hough_start", 32'(hough_start), 32'(m_hs));
      chk("m_bram_wr_en", 32'(bram_wr_en), 32'(wr_en_in & m_ready));
      chk("m_bram_wr_addr", 32'(bram_wr_addr), 32'({m_wb, wr_addr_in}));
      chk("m_bram_rd_addr", 32'(bram_rd_addr), 32'({m_rb, rd_addr_in}));
      chk("m_frames_written", 32'(frames_written), 32'(m_fw));
      chk("m_frames_read", 32'(frames_read), 32'(m_fr));
      chk("m_overrun_err", 32'(overrun_err), 32'(m_ov));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic          fd;
      logic [AW-1:0] ra;
      logic          rd;
      logic          e_ready;
      logic          e_hs;
      logic          e_wen;
      logic [AW:0]   e_wa;
      logic [AW:0]   e_ra;
      logic [15:0]   e_fw;
      logic [15:0]   e_fr;
      logic          e_ov;
   } vec_t;

   vec_t vecs [12];

   initial begin
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 1'b0);

      // Registered columns reflect all earlier rows; combinational columns
      // reflect the current row's inputs.
      vecs[0]  = '{1'b1, 18'h00123, 1'b0, 18'h00005, 1'b0, 1'b1, 1'b0, 1'b1, 19'h00123, 19'h00005, 16'd0, 16'd0, 1'b0};
      vecs[1]  = '{1'b0, 18'h3FFFF, 1'b1, 18'h00000, 1'b0, 1'b1, 1'b0, 1'b0, 19'h3FFFF, 19'h00000, 16'd0, 16'd0, 1'b0};
      vecs[2]  = '{1'b1, 18'h3FFFF, 1'b0, 18'h3FFFF, 1'b0, 1'b1, 1'b1, 1'b1, 19'h7FFFF, 19'h3FFFF, 16'd1, 16'd0, 1'b0};
      vecs[3]  = '{1'b0, 18'h00010, 1'b1, 18'h00001, 1'b0, 1'b1, 1'b0, 1'b0, 19'h40010, 19'h00001, 16'd1, 16'd0, 1'b0};
      vecs[4]  = '{1'b1, 18'h00020, 1'b0, 18'h00002, 1'b0, 1'b0, 1'b0, 1'b0, 19'h40020, 19'h00002, 16'd2, 16'd0, 1'b0};
      vecs[5]  = '{1'b0, 18'h00000, 1'b1, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 19'h40000, 19'h00000, 16'd2, 16'd0, 1'b1};
      vecs[6]  = '{1'b0, 18'h00000, 1'b0, 18'h00007, 1'b1, 1'b0, 1'b0, 1'b0, 19'h40000, 19'h00007, 16'd2, 16'd0, 1'b1};
      vecs[7]  = '{1'b0, 18'h00000, 1'b0, 18'h00007, 1'b0, 1'b0, 1'b1, 1'b0, 19'h40000, 19'h40007, 16'd2, 16'd1, 1'b1};
      vecs[8]  = '{1'b1, 18'h00055, 1'b0, 18'h00007, 1'b0, 1'b1, 1'b0, 1'b1, 19'h00055, 19'h40007, 16'd2, 16'd1, 1'b1};
      vecs[9]  = '{1'b0, 18'h00000, 1'b1, 18'h00000, 1'b1, 1'b1, 1'b0, 1'b0, 19'h00000, 19'h40000, 16'd2, 16'd1, 1'b1};
      vecs[10] = '{1'b0, 18'h00001, 1'b0, 18'h00003, 1'b0, 1'b1, 1'b1, 1'b0, 19'h40001, 19'h00003, 16'd3, 16'd2, 1'b1};
      vecs[11] = '{1'b0, 18'h00001, 1'b0, 18'h00003, 1'b0, 1'b1, 1'b0, 1'b0, 19'h40001, 19'h00003, 16'd3, 16'd2, 1'b1};

      // ---- reset values ----
      do_reset();
      #1;
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_hough_start", 32'(hough_start), 32'd0);
      chk("rst_overrun", 32'(overrun_err), 32'd0);
      chk("rst_frames_written", 32'(frames_written), 32'd0);
      chk("rst_frames_read", 32'(frames_read), 32'd0);

      // ---- table ----
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         drive(vecs[i].we, vecs[i].wa, vecs[i].fd, vecs[i].ra, vecs[i].rd);
         #1;
         chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_ready));
         chk($sformatf("v%0d_hough_start", i), 32'(hough_start), 32'(vecs[i].e_hs));
         chk($sformatf("v%0d_bram_wr_en", i), 32'(bram_wr_en), 32'(vecs[i].e_wen));
         chk($sformatf("v%0d_bram_wr_addr", i), 32'(bram_wr_addr), 32'(vecs[i].e_wa));
         chk($sformatf("v%0d_bram_rd_addr", i), 32'(bram_rd_addr), 32'(vecs[i].e_ra));
         chk($sformatf("v%0d_frames_written", i), 32'(frames_written), 32'(vecs[i].e_fw));
         chk($sformatf("v%0d_frames_read", i), 32'(frames_read), 32'(vecs[i].e_fr));
         chk($sformatf("v%0d_overrun", i), 32'(overrun_err), 32'(vecs[i].e_ov));
      end

      // ---- reset while bank0 is being read ----
      @(negedge clock);
      reset = 1'b0;
      drive(1'b0, 18'h00009, 1'b0, 18'h00004, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rr_wr_ready", 32'(wr_ready), 32'd1);
      chk("rr_overrun", 32'(overrun_err), 32'd0);
      chk("rr_frames_written", 32'(frames_written), 32'd0);
      chk("rr_frames_read", 32'(frames_read), 32'd0);
      chk("rr_bram_wr_addr", 32'(bram_wr_addr), 32'h00009);
      chk("rr_bram_rd_addr", 32'(bram_rd_addr), 32'h00004);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         #1;
         chk($sformatf("rr_no_start_%0d", i), 32'(hough_start), 32'd0);
      end

      // ---- randomized run against the model ----
      do_reset();
      model_reset();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         drive($urandom_range(0, 1) == 1, AW'($urandom), $urandom_range(0, 5) == 0,
               AW'($urandom), $urandom_range(0, 3) == 0);
         #1;
         check_model();
         model_step(wr_en_in, wr_frame_done, rd_done);
      end

      // ---- counter wrap: one frame written and read every cycle ----
      do_reset();
      model_reset();
      for (int i = 0; i < 65536; i++) begin
         @(negedge clock);
         drive(1'b0, '0, 1'b1, '0, 1'b1);
         if (i == 65535) begin
            #1;
            chk("wrap_fw_ffff", 32'(frames_written), 32'h0000FFFF);
            check_model();
         end
         model_step(wr_en_in, wr_frame_done, rd_done);
      end
      @(negedge clock);
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      #1;
      chk("wrap_fw_zero", 32'(frames_written), 32'h0);
      chk("wrap_fr_ffff", 32'(frames_read), 32'h0000FFFF);
      check_model();
      model_step(wr_en_in, wr_frame_done, rd_done);
      @(negedge clock);
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      #1;
      chk("wrap_fr_zero", 32'(frames_read), 32'h0);
      check_model();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
